// File: rtl/tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_pkg
// Description : Shared definitions for the decision-tree walkers: node word
//               field positions, the internal-node tag, the decoded node
//               struct and the walker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_pkg;

  // Node word field positions (bits above NODE_USED_W-1 are reserved)
  localparam int ID_MSB      = 107;
  localparam int ID_LSB      = 96;
  localparam int FEAT_MSB    = 95;
  localparam int FEAT_LSB    = 92;
  localparam int THR_MSB     = 91;
  localparam int THR_LSB     = 28;
  localparam int LEFT_MSB    = 27;
  localparam int LEFT_LSB    = 16;
  localparam int RIGHT_MSB   = 15;
  localparam int RIGHT_LSB   = 4;
  localparam int TAG_MSB     = 3;
  localparam int TAG_LSB     = 0;
  localparam int NODE_USED_W = 108;
  localparam int CHILD_W     = 12;

  localparam logic [3:0] TAG_INTERNAL = 4'h3;

  typedef struct packed {
    logic [11:0] id;
    logic [3:0]  feat;
    logic [63:0] thr;
    logic [11:0] left;
    logic [11:0] right;
    logic [3:0]  tag;
  } tree_node_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_FEAT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp64_le_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fp64_le_cmp
// Description : Combinational IEEE-754 double compare, le = (a <= b).
//               Sign-magnitude total order with -0 == +0. NaN not handled.
// Ports       : a, b  - 64-bit doubles
//               le    - 1 when a <= b
// Revision    : 1.0 - initial release
// ============================================================================
module fp64_le_cmp (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);

  logic        a_sign;
  logic        b_sign;
  logic [62:0] a_mag;
  logic [62:0] b_mag;
  logic        both_zero;

  assign a_sign    = a[63];
  assign b_sign    = b[63];
  assign a_mag     = a[62:0];
  assign b_mag     = b[62:0];
  assign both_zero = (a_mag == 63'd0) && (b_mag == 63'd0);

  // Differing signs: a <= b exactly when a is the negative one.
  // Both negative: larger magnitude is the smaller number.
  assign le = both_zero         ? 1'b1 :
              (a_sign != b_sign) ? a_sign :
              a_sign             ? (a_mag >= b_mag) :
                                   (a_mag <= b_mag);

endmodule
`default_nettype wire

// File: rtl/tree_walker_10.sv
`default_nettype none
// ============================================================================
// Module      : tree_walker_10
// Description : Walks the node ROM of tree 10 from ROOT_ADDR to a leaf.
//               Per internal node: WAIT (ROM latency) -> DECODE -> FEAT
//               (feature request/valid handshake, threshold compare) and
//               then the left (feat_val <= thr) or right child.
// Config      : TREE_WALKER_DEPTH_CHECK_EN - enables node-id, child-range
//               and depth checks driving result_err; when undefined
//               result_err is tied low and no depth counter exists.
// Ports       : clk, rst (async, active high)
//               start / busy              - walk control
//               rom_addr / node_data      - synchronous-read node ROM
//               feat_req/idx/vld/val      - feature fetch handshake
//               result_valid/class/err    - walk outcome
// Revision    : 1.0 - initial release
// ============================================================================
module tree_walker_10
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int ROM_DEPTH  = 512,
  parameter int ROOT_ADDR  = 0,
  parameter int MAX_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [NODE_WIDTH-1:0] node_data,
  output logic                  feat_req,
  output logic [3:0]            feat_idx,
  input  logic                  feat_vld,
  input  logic [63:0]           feat_val,
  output logic                  result_valid,
  output logic [3:0]            result_class,
  output logic                  result_err
);

  localparam logic [ADDR_WIDTH-1:0] ROOT = ADDR_WIDTH'(ROOT_ADDR);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  feat_req_q, feat_req_d;
  logic [3:0]            feat_idx_q, feat_idx_d;
  logic [63:0]           thr_q, thr_d;
  logic [CHILD_W-1:0]    left_q, left_d;
  logic [CHILD_W-1:0]    right_q, right_d;
  logic                  busy_q, busy_d;
  logic                  result_valid_q, result_valid_d;
  logic [3:0]            result_class_q, result_class_d;

  tree_node_t            node;
  logic                  go_left;
  logic [CHILD_W-1:0]    child;

  assign node.id    = node_data[ID_MSB:ID_LSB];
  assign node.feat  = node_data[FEAT_MSB:FEAT_LSB];
  assign node.thr   = node_data[THR_MSB:THR_LSB];
  assign node.left  = node_data[LEFT_MSB:LEFT_LSB];
  assign node.right = node_data[RIGHT_MSB:RIGHT_LSB];
  assign node.tag   = node_data[TAG_MSB:TAG_LSB];

  fp64_le_cmp u_cmp (
    .a  (feat_val),
    .b  (thr_q),
    .le (go_left)
  );

  assign child = go_left ? left_q : right_q;

`ifdef TREE_WALKER_DEPTH_CHECK_EN
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               result_err_q, result_err_d;
  logic               id_bad;
  logic               depth_bad;
  logic               child_bad;

  assign id_bad    = (node.id != CHILD_W'(rom_addr_q));
  assign depth_bad = (node.tag == TAG_INTERNAL) && (depth_q == DEPTH_W'(MAX_DEPTH));
  // Range check uses the full pointer, before truncation to ADDR_WIDTH.
  assign child_bad = (32'(child) >= ROM_DEPTH);
`endif

  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    feat_req_d     = feat_req_q;
    feat_idx_d     = feat_idx_q;
    thr_d          = thr_q;
    left_d         = left_q;
    right_d        = right_q;
    busy_d         = busy_q;
    result_valid_d = 1'b0;
    result_class_d = result_class_q;
`ifdef TREE_WALKER_DEPTH_CHECK_EN
    depth_d        = depth_q;
    result_err_d   = result_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT;
          rom_addr_d = ROOT;
          busy_d     = 1'b1;
`ifdef TREE_WALKER_DEPTH_CHECK_EN
          depth_d      = '0;
          result_err_d = 1'b0;
`endif
        end
      end

      ST_WAIT: state_d = ST_DECODE;

      ST_DECODE: begin
`ifdef TREE_WALKER_DEPTH_CHECK_EN
        if (id_bad || depth_bad) begin
          result_err_d   = 1'b1;
          result_class_d = 4'h0;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else
`endif
        if (node.tag != TAG_INTERNAL) begin
          result_class_d = node.tag;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          thr_d      = node.thr;
          left_d     = node.left;
          right_d    = node.right;
          feat_idx_d = node.feat;
          feat_req_d = 1'b1;
          state_d    = ST_FEAT;
        end
      end

      ST_FEAT: begin
        if (feat_vld && feat_req_q) begin
          feat_req_d = 1'b0;
`ifdef TREE_WALKER_DEPTH_CHECK_EN
          depth_d = depth_q + DEPTH_W'(1);
          if (child_bad) begin
            result_err_d   = 1'b1;
            result_class_d = 4'h0;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else
`endif
          begin
            rom_addr_d = child[ADDR_WIDTH-1:0];
            state_d    = ST_WAIT;
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rom_addr_q     <= ROOT;
      feat_req_q     <= 1'b0;
      feat_idx_q     <= 4'h0;
      thr_q          <= 64'h0;
      left_q         <= '0;
      right_q        <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= 4'h0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      feat_req_q     <= feat_req_d;
      feat_idx_q     <= feat_idx_d;
      thr_q          <= thr_d;
      left_q         <= left_d;
      right_q        <= right_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
    end
  end

`ifdef TREE_WALKER_DEPTH_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q      <= '0;
      result_err_q <= 1'b0;
    end else begin
      depth_q      <= depth_d;
      result_err_q <= result_err_d;
    end
  end

  assign result_err = result_err_q;
`else
  assign result_err = 1'b0;
`endif

  // Reserved ROM bits and pointer bits above ADDR_WIDTH are only
  // consumed by the optional checks.
  localparam int unused_rom_depth = ROM_DEPTH;
  localparam int unused_max_depth = MAX_DEPTH;
  logic unused_bits;
  assign unused_bits = ^{node_data[NODE_WIDTH-1:NODE_USED_W], node.id,
                         child[CHILD_W-1:ADDR_WIDTH]};

  assign busy         = busy_q;
  assign rom_addr     = rom_addr_q;
  assign feat_req     = feat_req_q;
  assign feat_idx     = feat_idx_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_walker_10.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_walker_10
// Description : Scoreboard bench for tree_walker_10. A ROM model and a
//               feature responder surround the DUT; each walk pushes its
//               hand-computed outcome, a monitor pops on result_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_walker_10;

  localparam logic [63:0] D843_5  = 64'h408A5C0000000000;
  localparam logic [63:0] D843_6  = 64'h408A5CCCCCCCCCCD;
  localparam logic [63:0] D0_5    = 64'h3FE0000000000000;
  localparam logic [63:0] D1      = 64'h3FF0000000000000;
  localparam logic [63:0] D1_5    = 64'h3FF8000000000000;
  localparam logic [63:0] D2      = 64'h4000000000000000;
  localparam logic [63:0] D2_UP   = 64'h4000000000000001;
  localparam logic [63:0] DN1     = 64'hBFF0000000000000;
  localparam logic [63:0] DN2     = 64'hC000000000000000;
  localparam logic [63:0] DN0_5   = 64'hBFE0000000000000;
  localparam logic [63:0] DN0     = 64'h8000000000000000;
  localparam logic [63:0] DP0     = 64'h0000000000000000;
  localparam logic [63:0] DTINY   = 64'h0000000000000001;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic [9:0]   rom_addr;
  logic [119:0] node_data;
  logic         feat_req;
  logic [3:0]   feat_idx;
  logic         feat_vld;
  logic [63:0]  feat_val;
  logic         result_valid;
  logic [3:0]   result_class;
  logic         result_err;

  tree_walker_10 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .rom_addr     (rom_addr),
    .node_data    (node_data),
    .feat_req     (feat_req),
    .feat_idx     (feat_idx),
    .feat_vld     (feat_vld),
    .feat_val     (feat_val),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_err   (result_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [119:0] rom [0:1023];
  always @(posedge clk) node_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [119:0] mk(input logic [11:0] id, input logic [3:0] f,
                                      input logic [63:0] t, input logic [11:0] l,
                                      input logic [11:0] r, input logic [3:0] tag);
    mk = {12'h000, id, f, t, l, r, tag};
  endfunction

  // Scoreboard
  typedef struct {
    logic [3:0]  cls;
    logic        err;
    int          lat;
    int          np;
    logic [31:0] tr;
    int          t0;
  } exp_t;
  exp_t exp_q[$];

  // Feature responder state
  logic [63:0] feat_mem [0:15];
  int          npulse   = 0;
  logic [31:0] trace    = 0;
  int          cur_wait = 0;
  bit          resp_en  = 1'b1;
  int          valid_count = 0;

  initial begin
    bit         in_req;
    int         wcnt;
    logic [3:0] cap_idx;
    logic [9:0] cap_addr;
    in_req   = 1'b0;
    wcnt     = 0;
    cap_idx  = 4'h0;
    cap_addr = 10'h0;
    feat_vld = 1'b0;
    feat_val = 64'h0;
    forever begin
      @(posedge clk);
      #1;
      feat_vld = 1'b0;
      if (feat_req && !rst) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wcnt     = 0;
          cap_idx  = feat_idx;
          cap_addr = rom_addr;
          npulse++;
          trace = {trace[27:0], feat_idx};
        end else begin
          chk("stall_req", {63'h0, feat_req}, 64'h1);
          chk("stall_idx", {60'h0, feat_idx}, {60'h0, cap_idx});
          chk("stall_addr", {54'h0, rom_addr}, {54'h0, cap_addr});
        end
        if (resp_en && wcnt >= cur_wait) begin
          feat_vld = 1'b1;
          feat_val = feat_mem[feat_idx];
          in_req   = 1'b0;
          cur_wait = 0;
        end else begin
          wcnt++;
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        valid_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=valid required=none class=%0h", result_class);
        end else begin
          e = exp_q.pop_front();
          chk("class", {60'h0, result_class}, {60'h0, e.cls});
          chk("err", {63'h0, result_err}, {63'h0, e.err});
          chk("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
          chk("feat_pulses", 64'(npulse), 64'(e.np));
          chk("feat_idx_trace", {32'h0, trace}, {32'h0, e.tr});
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic setf(input logic [63:0] f1, input logic [63:0] f2, input logic [63:0] f5,
                      input logic [63:0] f7, input logic [63:0] f9);
    for (int i = 0; i < 16; i++) feat_mem[i] = 64'h0;
    feat_mem[1] = f1;
    feat_mem[2] = f2;
    feat_mem[5] = f5;
    feat_mem[7] = f7;
    feat_mem[9] = f9;
  endtask

  task automatic run_walk(input logic [3:0] cls, input logic err, input int lat,
                          input int np, input logic [31:0] tr, input int first_wait,
                          input bit poke);
    exp_t e;
    int   old;
    int   n;
    wait_idle();
    npulse   = 0;
    trace    = 0;
    cur_wait = first_wait;
    old      = valid_count;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e.cls = cls; e.err = err; e.lat = lat; e.np = np; e.tr = tr; e.t0 = cyc;
    exp_q.push_back(e);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while (valid_count == old && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (valid_count == old) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=none required=result_valid");
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int old;
    int n;
    start = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = 120'h0;
    for (int i = 0; i < 16; i++) feat_mem[i] = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", {54'h0, rom_addr}, 64'h0);
    chk("rst_feat_idx", {60'h0, feat_idx}, 64'h0);
    chk("rst_class", {60'h0, result_class}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_feat_req", {63'h0, feat_req}, 64'h0);
    chk("rst_valid", {63'h0, result_valid}, 64'h0);
    chk("rst_err", {63'h0, result_err}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Root leaf
    rom[0] = mk(12'd0, 4'd0, 64'h0, 12'd0, 12'd0, 4'h1);
    run_walk(4'h1, 1'b0, 3, 0, 32'h0, 0, 1'b0);

    // Three-level tree
    rom[0]  = mk(12'd0, 4'd2, D843_5, 12'd1, 12'd2, 4'h3);
    rom[1]  = mk(12'd1, 4'd5, D1,     12'd3, 12'd4, 4'h3);
    rom[2]  = mk(12'd2, 4'd7, DN1,    12'd5, 12'd6, 4'h3);
    rom[3]  = mk(12'd3, 4'd9, DN0,    12'd7, 12'd8, 4'h3);
    rom[4]  = mk(12'd4, 4'd0, 64'h0,  12'd0, 12'd0, 4'h4);
    rom[5]  = mk(12'd5, 4'd1, D2,     12'd9, 12'd10, 4'h3);
    rom[6]  = mk(12'd6, 4'd0, 64'h0,  12'd0, 12'd0, 4'h6);
    rom[7]  = mk(12'd7, 4'd0, 64'h0,  12'd0, 12'd0, 4'h7);
    rom[8]  = mk(12'd8, 4'd0, 64'h0,  12'd0, 12'd0, 4'h8);
    rom[9]  = mk(12'd9, 4'd0, 64'h0,  12'd0, 12'd0, 4'h9);
    rom[10] = mk(12'd10, 4'd0, 64'h0, 12'd0, 12'd0, 4'hA);

    setf(DP0, D843_5, D0_5, DP0, DP0);     // left,left,(+0 vs -0) left
    run_walk(4'h7, 1'b0, 12, 3, 32'h259, 0, 1'b0);
    setf(D2, D843_6, DP0, DN2, DP0);       // right, -2<=-1 left, 2<=2 left
    run_walk(4'h9, 1'b0, 12, 3, 32'h271, 0, 1'b0);
    setf(DP0, D843_6, DP0, D0_5, DP0);     // right, 0.5 > -1 right
    run_walk(4'h6, 1'b0, 9, 2, 32'h27, 0, 1'b0);
    setf(DP0, D843_5, D1_5, DP0, DP0);     // left, 1.5 > 1 right
    run_walk(4'h4, 1'b0, 9, 2, 32'h25, 0, 1'b0);
    setf(DP0, D843_6, DP0, DN0_5, DP0);    // right, -0.5 > -1 right
    run_walk(4'h6, 1'b0, 9, 2, 32'h27, 0, 1'b0);
    setf(DP0, D843_5, D0_5, DP0, DTINY);   // smallest positive > -0 right
    run_walk(4'h8, 1'b0, 12, 3, 32'h259, 0, 1'b0);
    setf(D2_UP, D843_6, DP0, DN2, DP0);    // one ulp above 2.0 right
    run_walk(4'hA, 1'b0, 12, 3, 32'h271, 0, 1'b0);

    // Feature stall of 4 extra FEAT cycles on the root request
    setf(DP0, D843_5, D0_5, DP0, DP0);
    run_walk(4'h7, 1'b0, 16, 3, 32'h259, 4, 1'b0);

    // start pulsed while busy must not disturb the walk
    setf(D2, D843_6, DP0, DN2, DP0);
    run_walk(4'h9, 1'b0, 12, 3, 32'h271, 0, 1'b1);

    // Reset in FEAT: outputs drop immediately, no result appears
    wait_idle();
    resp_en = 1'b0;
    old = valid_count;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!feat_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_feat", {63'h0, feat_req}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", {63'h0, busy}, 64'h0);
    chk("async_feat_req", {63'h0, feat_req}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resp_en = 1'b1;
    chk("post_rst_addr", {54'h0, rom_addr}, 64'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("no_result_after_rst", 64'(valid_count), 64'(old));

`ifdef TREE_WALKER_DEPTH_CHECK_EN
    rom[0] = mk(12'd5, 4'd0, 64'h0, 12'd0, 12'd0, 4'h2);
    run_walk(4'h0, 1'b1, 3, 0, 32'h0, 0, 1'b0);
    rom[0] = mk(12'd0, 4'd2, D843_5, 12'h200, 12'd2, 4'h3);
    setf(DP0, D843_5, DP0, DP0, DP0);
    run_walk(4'h0, 1'b1, 4, 1, 32'h2, 0, 1'b0);
`else
    // Pointer 0x401 truncates to address 1
    rom[0] = mk(12'd0, 4'd2, D843_5, 12'h401, 12'd2, 4'h3);
    setf(DP0, D843_5, D0_5, DP0, DP0);
    run_walk(4'h7, 1'b0, 12, 3, 32'h259, 0, 1'b0);
`endif

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
